// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back register file slice.
// Provides GPR index width, data width and the hardwired-zero index.
package wb_regfile_pkg;
   localparam int REG_W = 5;
   localparam int DATA_W = 32;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_regfile_gpr_array.sv
// gpr_array: NREG x 32 storage, one write port, two async read ports.
// Ports: clk, rst (async clear), we/waddr/wdata, raddr_a/b -> rdata_a/b.
module gpr_array
   import wb_regfile_pkg::*;
#(
   parameter int NREG = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [REG_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [REG_W-1:0]  raddr_a,
   input  logic [REG_W-1:0]  raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b
);

   logic [DATA_W-1:0] mem [NREG];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            mem[i] <= '0;
         end
      end else if (we && (int'(waddr) < NREG)) begin
         mem[waddr] <= wdata;
      end
   end

   // Indices beyond NREG read as zero when built smaller than 32.
   assign rdata_a = (int'(raddr_a) < NREG) ? mem[raddr_a] : '0;
   assign rdata_b = (int'(raddr_b) < NREG) ? mem[raddr_b] : '0;

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: result mux, GPR commit with same-cycle read bypass,
// retire/overflow counters and sticky overflow-trap flag.
// Ports: Clk, Reset, W_* write-back bundle, Ra/Rb -> busA/busB,
// Exc_Clr -> Exc_Flag/Exc_Rw, RetireCnt, OvfCnt.
module wb_regfile
   import wb_regfile_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int NREG  = 32
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              W_Valid,
   input  logic              W_RegWr,
   input  logic              W_MemtoReg,
   input  logic              W_OvCheck,
   input  logic [DATA_W-1:0] W_Dout,
   input  logic [DATA_W-1:0] W_ALUout,
   input  logic              W_Overflow,
   input  logic [REG_W-1:0]  W_Rw,
   input  logic [REG_W-1:0]  Ra,
   input  logic [REG_W-1:0]  Rb,
   output logic [DATA_W-1:0] busA,
   output logic [DATA_W-1:0] busB,
   input  logic              Exc_Clr,
   output logic              Exc_Flag,
   output logic [REG_W-1:0]  Exc_Rw,
   output logic [CNT_W-1:0]  RetireCnt,
   output logic [CNT_W-1:0]  OvfCnt
);

   logic [DATA_W-1:0] busW;
   logic              trap;
   logic              we;
   logic [DATA_W-1:0] rd_a;
   logic [DATA_W-1:0] rd_b;

   assign busW = W_MemtoReg ? W_Dout : W_ALUout;
   assign trap = W_Valid & W_OvCheck & W_Overflow;
   assign we   = W_Valid & W_RegWr
               & (W_Rw != REG_ZERO) & ~trap;

   gpr_array #(
      .NREG (NREG)
   ) u_gpr (
      .clk     (Clk),
      .rst     (Reset),
      .we      (we),
      .waddr   (W_Rw),
      .wdata   (busW),
      .raddr_a (Ra),
      .raddr_b (Rb),
      .rdata_a (rd_a),
      .rdata_b (rd_b)
   );

   // The arms are disjoint: we already excludes W_Rw == $0.
   always_comb begin
      busA = rd_a;
      unique case (1'b1)
         (Ra == REG_ZERO):      busA = '0;
         (we && (Ra == W_Rw)):  busA = busW;
         default:               busA = rd_a;
      endcase
   end

   always_comb begin
      busB = rd_b;
      unique case (1'b1)
         (Rb == REG_ZERO):      busB = '0;
         (we && (Rb == W_Rw)):  busB = busW;
         default:               busB = rd_b;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         RetireCnt <= '0;
         OvfCnt    <= '0;
         Exc_Flag  <= 1'b0;
         Exc_Rw    <= '0;
      end else begin
         if (we) begin
            RetireCnt <= RetireCnt + 1'b1;
         end
         if (trap) begin
            OvfCnt <= OvfCnt + 1'b1;
            Exc_Rw <= W_Rw;
         end
         // A new trap wins over a simultaneous clear.
         if (trap) begin
            Exc_Flag <= 1'b1;
         end else if (Exc_Clr) begin
            Exc_Flag <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed literal checks plus randomized
// traffic compared every cycle against a behavioural model.
module tb_wb_regfile;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        W_Valid, W_RegWr, W_MemtoReg, W_OvCheck;
   logic [31:0] W_Dout, W_ALUout;
   logic        W_Overflow;
   logic [4:0]  W_Rw, Ra, Rb;
   logic [31:0] busA, busB;
   logic        Exc_Clr, Exc_Flag;
   logic [4:0]  Exc_Rw;
   logic [15:0] RetireCnt, OvfCnt;

   wb_regfile #(.CNT_W(16), .NREG(32)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .W_Valid    (W_Valid),
      .W_RegWr    (W_RegWr),
      .W_MemtoReg (W_MemtoReg),
      .W_OvCheck  (W_OvCheck),
      .W_Dout     (W_Dout),
      .W_ALUout   (W_ALUout),
      .W_Overflow (W_Overflow),
      .W_Rw       (W_Rw),
      .Ra         (Ra),
      .Rb         (Rb),
      .busA       (busA),
      .busB       (busB),
      .Exc_Clr    (Exc_Clr),
      .Exc_Flag   (Exc_Flag),
      .Exc_Rw     (Exc_Rw),
      .RetireCnt  (RetireCnt),
      .OvfCnt     (OvfCnt)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   // Behavioural model: architectural register contents and counters.
   logic [31:0] m_gpr [32];
   logic [15:0] m_ret = '0;
   logic [15:0] m_ovf = '0;
   logic        m_flag = 1'b0;
   logic [4:0]  m_rw = '0;

   function automatic logic [31:0] m_busw();
      return W_MemtoReg ? W_Dout : W_ALUout;
   endfunction

   function automatic bit m_trap();
      return W_Valid && W_OvCheck && W_Overflow;
   endfunction

   function automatic bit m_we();
      return W_Valid && W_RegWr && (W_Rw != 0) && !m_trap();
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] r);
      if (r == 0) return 32'd0;
      if (m_we() && r == W_Rw) return m_busw();
      return m_gpr[r];
   endfunction

   initial begin
      for (int i = 0; i < 32; i++) m_gpr[i] = '0;
   end

   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < 32; i++) m_gpr[i] <= '0;
         m_ret  <= '0;
         m_ovf  <= '0;
         m_flag <= 1'b0;
         m_rw   <= '0;
      end else begin
         if (m_we()) begin
            m_gpr[W_Rw] <= m_busw();
            m_ret <= m_ret + 16'd1;
         end
         if (m_trap()) begin
            m_ovf  <= m_ovf + 16'd1;
            m_rw   <= W_Rw;
            m_flag <= 1'b1;
         end else if (Exc_Clr) begin
            m_flag <= 1'b0;
         end
      end
   end

   // Compare process: mid-cycle, well away from the rising edge.
   always @(negedge Clk) begin
      #3;
      if (chk_en) begin
         check("busA", busA, m_read(Ra));
         check("busB", busB, m_read(Rb));
         check("RetireCnt", 32'(RetireCnt), 32'(m_ret));
         check("OvfCnt", 32'(OvfCnt), 32'(m_ovf));
         check("Exc_Flag", 32'(Exc_Flag), 32'(m_flag));
         check("Exc_Rw", 32'(Exc_Rw), 32'(m_rw));
      end
   end

   task automatic idle();
      W_Valid = 0; W_RegWr = 0; W_MemtoReg = 0;
      W_OvCheck = 0; W_Overflow = 0;
      W_Dout = '0; W_ALUout = '0; W_Rw = '0;
      Exc_Clr = 0;
   endtask

   task automatic wr(input logic [4:0] rw, input logic [31:0] d);
      idle();
      W_Valid = 1; W_RegWr = 1; W_ALUout = d; W_Rw = rw;
   endtask

   task automatic trap_op(input logic [4:0] rw, input logic [31:0] d);
      wr(rw, d);
      W_OvCheck = 1; W_Overflow = 1;
   endtask

   initial begin
      int n;
      idle();
      Ra = '0; Rb = '0;
      Reset = 1'b1;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      chk_en = 1'b1;

      // Reset state
      for (int r = 0; r < 32; r++) begin
         @(negedge Clk);
         Ra = 5'(r); Rb = 5'(31 - r);
         #1;
         check("rst_busA", busA, 32'd0);
         check("rst_busB", busB, 32'd0);
      end
      check("rst_ret", 32'(RetireCnt), 32'd0);
      check("rst_ovf", 32'(OvfCnt), 32'd0);
      check("rst_flag", 32'(Exc_Flag), 32'd0);

      // Bypass then stored read
      @(negedge Clk);
      wr(5, 32'h1234_5678); Ra = 5;
      #1 check("bypass", busA, 32'h1234_5678);
      @(negedge Clk);
      idle(); Ra = 5;
      #1 check("stored", busA, 32'h1234_5678);
      check("ret1", 32'(RetireCnt), 32'd1);

      // Write to $0 discarded
      @(negedge Clk);
      wr(0, 32'h1); W_MemtoReg = 1; W_Dout = 32'hDEAD_BEEF; Ra = 0;
      #1 check("r0_byp", busA, 32'd0);
      @(negedge Clk);
      idle(); Ra = 0;
      #1 check("r0_read", busA, 32'd0);
      check("r0_ret", 32'(RetireCnt), 32'd1);

      // Trap suppresses write
      @(negedge Clk);
      wr(9, 32'd7);
      @(negedge Clk);
      trap_op(9, 32'd99); Ra = 9;
      #1 check("trap_nobyp", busA, 32'd7);
      @(negedge Clk);
      idle(); Ra = 9;
      #1 check("trap_keep", busA, 32'd7);
      check("trap_flag", 32'(Exc_Flag), 32'd1);
      check("trap_rw", 32'(Exc_Rw), 32'd9);
      check("trap_ovf", 32'(OvfCnt), 32'd1);
      check("trap_ret", 32'(RetireCnt), 32'd2);
      @(negedge Clk);
      wr(9, 32'd99); W_Overflow = 1; Ra = 9;
      #1 check("nochk_byp", busA, 32'd99);
      @(negedge Clk);
      idle(); Ra = 9;
      #1 check("nochk_wr", busA, 32'd99);
      check("nochk_ovf", 32'(OvfCnt), 32'd1);

      // Set beats clear, then clear alone
      @(negedge Clk);
      trap_op(3, 32'd1); Exc_Clr = 1;
      @(negedge Clk);
      idle(); Exc_Clr = 1;
      #1 check("setpri", 32'(Exc_Flag), 32'd1);
      check("setpri_rw", 32'(Exc_Rw), 32'd3);
      @(negedge Clk);
      idle();
      #1 check("clr", 32'(Exc_Flag), 32'd0);
      check("clr_ovf", 32'(OvfCnt), 32'd2);

      // Randomized traffic
      repeat (2000) begin
         @(negedge Clk);
         W_Valid    = ($urandom_range(0, 3) != 0);
         W_RegWr    = ($urandom_range(0, 3) != 0);
         W_MemtoReg = 1'($urandom);
         W_OvCheck  = ($urandom_range(0, 3) == 0);
         W_Overflow = 1'($urandom);
         W_Dout     = $urandom;
         W_ALUout   = $urandom;
         W_Rw       = 5'($urandom);
         Ra         = 5'($urandom);
         Rb         = ($urandom_range(0, 3) == 0) ? W_Rw
                                                 : 5'($urandom);
         Exc_Clr    = ($urandom_range(0, 7) == 0);
      end

      // Retire counter wrap
      @(negedge Clk);
      idle();
      #1 n = 16'hFFFF - int'(m_ret);
      for (int i = 0; i < n; i++) begin
         @(negedge Clk);
         wr(5'(i % 31 + 1), 32'(i));
      end
      @(negedge Clk);
      idle();
      #1 check("ret_full", 32'(RetireCnt), 32'h0000_FFFF);
      @(negedge Clk);
      wr(4, 32'hA5A5_0001);
      @(negedge Clk);
      idle();
      #1 check("ret_wrap", 32'(RetireCnt), 32'd0);

      // Asynchronous reset mid-cycle
      @(negedge Clk);
      trap_op(6, 32'd5);
      @(negedge Clk);
      wr(7, 32'hCAFE_F00D); Ra = 7; Rb = 4;
      #1 check("pre_flag", 32'(Exc_Flag), 32'd1);
      check("pre_busB", busB, 32'hA5A5_0001);
      #1 Reset = 1'b1;
      #1 check("ar_busB", busB, 32'd0);
      check("ar_byp", busA, 32'hCAFE_F00D);
      check("ar_ret", 32'(RetireCnt), 32'd0);
      check("ar_ovf", 32'(OvfCnt), 32'd0);
      check("ar_flag", 32'(Exc_Flag), 32'd0);
      check("ar_rw", 32'(Exc_Rw), 32'd0);
      @(negedge Clk);
      Reset = 1'b0;
      idle(); Ra = 7;
      #1 check("ar_nocommit", busA, 32'd0);
      check("ar_ret2", 32'(RetireCnt), 32'd0);
      @(negedge Clk);
      wr(7, 32'd42);
      @(negedge Clk);
      idle(); Ra = 7;
      #1 check("post_rst_wr", busA, 32'd42);
      check("post_rst_ret", 32'(RetireCnt), 32'd1);

      @(negedge Clk);
      #4 chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
